// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU arithmetic unit, the result stage and its consumer.
// Latency: none (wires only).
// Backpressure: in_ready throttles the producer, out_ready throttles the stage.
interface alu_result_stage_if #(
    parameter int WIDTH = 8
);
    // Upstream side: one ALU result per accepted handshake
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] C;
    logic             zero_flag;
    logic             over_flow_flag;
    logic             carry_out;

    // Downstream side: head of the result queue
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [1:0]       out_op;
    logic             out_zero;
    logic             out_ovf;
    logic             out_carry;

    // Environment view: drives results in, consumes results out
    modport master (
        output in_valid, in_op, C, zero_flag, over_flow_flag, carry_out, out_ready,
        input  in_ready, out_valid, out_result, out_op, out_zero, out_ovf, out_carry
    );

    // Stage view
    modport slave (
        input  in_valid, in_op, C, zero_flag, over_flow_flag, carry_out, out_ready,
        output in_ready, out_valid, out_result, out_op, out_zero, out_ovf, out_carry
    );
endinterface

// File: rtl/alu_result_stage.sv
// Buffers ALU results (value, op, zero/ovf/carry) in a DEPTH-entry FIFO and keeps sticky status flags.
// Latency: a result accepted on edge N is presented on out_* from cycle N+1; illegal op 2'b10 is dropped.
// Backpressure: in_ready = registered count < DEPTH; a pop never frees a slot in the same cycle.
// Optional statistics counters are built when ALU_RESULT_STATS_EN is defined.
module alu_result_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic               CLK,
    input  logic               RST,
    alu_result_stage_if.slave  bus,
    input  logic               clr_sticky,
    output logic               sticky_ovf,
    output logic               sticky_carry,
    output logic               sticky_illegal
`ifdef ALU_RESULT_STATS_EN
    ,
    output logic [15:0]        result_count,
    output logic [7:0]         ovf_count,
    output logic [15:0]        stall_cycles
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [1:0] OP_ILLEGAL = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [1:0]       op;
        logic             zero;
        logic             ovf;
        logic             carry;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_carry_q, sticky_carry_d;
    logic             sticky_illegal_q, sticky_illegal_d;

    logic   push;
    logic   wr_en;
    logic   pop;
    logic   not_empty;
    entry_t head;
    entry_t new_entry;

    // Handshake decode: ready comes from the registered count only, so a pop cannot make room this cycle
    always_comb begin
        not_empty    = (count_q != '0);
        bus.in_ready = (count_q < CNT_W'(DEPTH));
        push         = bus.in_valid & bus.in_ready;
        wr_en        = push & (bus.in_op != OP_ILLEGAL);
        pop          = not_empty & bus.out_ready;
    end

    // Present the head entry straight from storage; zeros whenever the queue is empty
    always_comb begin
        head              = mem_q[rd_ptr_q];
        bus.out_valid     = not_empty;
        bus.out_result    = not_empty ? head.result : '0;
        bus.out_op        = not_empty ? head.op     : 2'b00;
        bus.out_zero      = not_empty & head.zero;
        bus.out_ovf       = not_empty & head.ovf;
        bus.out_carry     = not_empty & head.carry;
    end

    // Next-state for storage, pointers and occupancy
    always_comb begin
        new_entry.result = bus.C;
        new_entry.op     = bus.in_op;
        new_entry.zero   = bus.zero_flag;
        new_entry.ovf    = bus.over_flow_flag;
        new_entry.carry  = bus.carry_out;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = new_entry;
            // DEPTH is a power of two, so the natural wrap of the pointer is modulo DEPTH
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky flags: a clear drops the old value but an event in the same cycle still sets the flag
    always_comb begin
        sticky_ovf_d     = (clr_sticky ? 1'b0 : sticky_ovf_q)     | (wr_en & bus.over_flow_flag);
        sticky_carry_d   = (clr_sticky ? 1'b0 : sticky_carry_q)   | (wr_en & bus.carry_out);
        sticky_illegal_d = (clr_sticky ? 1'b0 : sticky_illegal_q) | (push & (bus.in_op == OP_ILLEGAL));
    end

    // Queue and status state; reset flushes every entry at once
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            sticky_ovf_q     <= 1'b0;
            sticky_carry_q   <= 1'b0;
            sticky_illegal_q <= 1'b0;
        end else begin
            mem_q            <= mem_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            sticky_ovf_q     <= sticky_ovf_d;
            sticky_carry_q   <= sticky_carry_d;
            sticky_illegal_q <= sticky_illegal_d;
        end
    end

    assign sticky_ovf     = sticky_ovf_q;
    assign sticky_carry   = sticky_carry_q;
    assign sticky_illegal = sticky_illegal_q;

`ifdef ALU_RESULT_STATS_EN
    logic [15:0] result_count_q, result_count_d;
    logic [7:0]  ovf_count_q, ovf_count_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] rc_base;
    logic [7:0]  oc_base;
    logic [15:0] sc_base;

    // Saturating counters; clr_sticky restarts them but this cycle's event still counts
    always_comb begin
        rc_base = clr_sticky ? 16'h0 : result_count_q;
        oc_base = clr_sticky ? 8'h0  : ovf_count_q;
        sc_base = clr_sticky ? 16'h0 : stall_cycles_q;

        result_count_d = rc_base;
        ovf_count_d    = oc_base;
        stall_cycles_d = sc_base;

        if (wr_en && rc_base != 16'hFFFF) begin
            result_count_d = rc_base + 16'd1;
        end
        if (wr_en && bus.over_flow_flag && oc_base != 8'hFF) begin
            ovf_count_d = oc_base + 8'd1;
        end
        if (not_empty && !bus.out_ready && sc_base != 16'hFFFF) begin
            stall_cycles_d = sc_base + 16'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            result_count_q <= '0;
            ovf_count_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            result_count_q <= result_count_d;
            ovf_count_q    <= ovf_count_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign result_count = result_count_q;
    assign ovf_count    = ovf_count_q;
    assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios followed by random traffic,
// all compared against a queue-based model of the result stage.
// Inputs change just after the falling edge; outputs are sampled 1ns later, away from the rising edge.
module tb_alu_result_stage;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic clr_sticky = 1'b0;
    logic sticky_ovf, sticky_carry, sticky_illegal;
`ifdef ALU_RESULT_STATS_EN
    logic [15:0] result_count;
    logic [7:0]  ovf_count;
    logic [15:0] stall_cycles;
`endif

    alu_result_stage_if #(.WIDTH(WIDTH)) bus ();

    always #5 CLK = ~CLK;

    alu_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .bus            (bus),
        .clr_sticky     (clr_sticky),
        .sticky_ovf     (sticky_ovf),
        .sticky_carry   (sticky_carry),
        .sticky_illegal (sticky_illegal)
`ifdef ALU_RESULT_STATS_EN
        ,
        .result_count   (result_count),
        .ovf_count      (ovf_count),
        .stall_cycles   (stall_cycles)
`endif
    );

    typedef struct {
        logic [7:0] res;
        logic [1:0] op;
        logic       z;
        logic       o;
        logic       c;
    } ent_t;

    ent_t mq[$];
    bit   m_sovf, m_scar, m_sill;
    int   m_rc, m_oc, m_sc;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_sovf = 0; m_scar = 0; m_sill = 0;
        m_rc = 0; m_oc = 0; m_sc = 0;
    endtask

    task automatic check_outputs();
        check("in_ready", {31'b0, bus.in_ready}, (mq.size() < DEPTH) ? 32'd1 : 32'd0);
        check("out_valid", {31'b0, bus.out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
        if (mq.size() != 0) begin
            check("out_result", {24'b0, bus.out_result}, {24'b0, mq[0].res});
            check("out_op",     {30'b0, bus.out_op},     {30'b0, mq[0].op});
            check("out_zero",   {31'b0, bus.out_zero},   {31'b0, mq[0].z});
            check("out_ovf",    {31'b0, bus.out_ovf},    {31'b0, mq[0].o});
            check("out_carry",  {31'b0, bus.out_carry},  {31'b0, mq[0].c});
        end else begin
            check("out_data_empty",
                  {19'b0, bus.out_result, bus.out_op, bus.out_zero, bus.out_ovf, bus.out_carry}, 32'd0);
        end
        check("sticky_ovf",     {31'b0, sticky_ovf},     {31'b0, m_sovf});
        check("sticky_carry",   {31'b0, sticky_carry},   {31'b0, m_scar});
        check("sticky_illegal", {31'b0, sticky_illegal}, {31'b0, m_sill});
`ifdef ALU_RESULT_STATS_EN
        check("result_count", {16'b0, result_count}, m_rc);
        check("ovf_count",    {24'b0, ovf_count},    m_oc);
        check("stall_cycles", {16'b0, stall_cycles}, m_sc);
`endif
    endtask

    // One clock cycle: drive inputs, check the stage, then advance the model across the rising edge
    task automatic cycle(input bit v, input bit [1:0] op, input bit [7:0] c, input bit z,
                         input bit o, input bit cy, input bit ordy, input bit clr);
        bit   push, pop, stall;
        ent_t e;
        @(negedge CLK);
        bus.in_valid       = v;
        bus.in_op          = op;
        bus.C              = c;
        bus.zero_flag      = z;
        bus.over_flow_flag = o;
        bus.carry_out      = cy;
        bus.out_ready      = ordy;
        clr_sticky         = clr;
        #1;
        check_outputs();
        push  = v && (mq.size() < DEPTH);
        pop   = (mq.size() != 0) && ordy;
        stall = (mq.size() != 0) && !ordy;
        @(posedge CLK);
        if (pop) mq.delete(0);
        if (clr) begin
            m_sovf = 0; m_scar = 0; m_sill = 0;
            m_rc = 0; m_oc = 0; m_sc = 0;
        end
        if (stall && m_sc < 65535) m_sc++;
        if (push) begin
            if (op == 2'b10) begin
                m_sill = 1;
            end else begin
                e.res = c; e.op = op; e.z = z; e.o = o; e.c = cy;
                mq.push_back(e);
                m_sovf |= o;
                m_scar |= cy;
                if (m_rc < 65535) m_rc++;
                if (o && m_oc < 255) m_oc++;
            end
        end
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_op = 0; bus.C = 0; bus.zero_flag = 0;
        bus.over_flow_flag = 0; bus.carry_out = 0; bus.out_ready = 0;
        model_reset();

        // Reset state
        #2;
        check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_out_result", {24'b0, bus.out_result}, 32'd0);
        check("rst_sticky", {29'b0, sticky_ovf, sticky_carry, sticky_illegal}, 32'd0);
        #10 RST = 1'b1;

        // Single push with every flag set, consumer ready
        cycle(1'b1, 2'b00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("tp1_out_zero", {31'b0, bus.out_zero}, 32'd1);
        idle(1'b1);
        check("tp1_drained", {31'b0, bus.out_valid}, 32'd0);
        check("tp1_sticky", {30'b0, sticky_ovf, sticky_carry}, 32'd3);

        // Fill while stalled, hold a third result off, then drain in order
        cycle(1'b1, 2'b01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 2'b11, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("tp2_full_ready", {31'b0, bus.in_ready}, 32'd0);
        cycle(1'b1, 2'b11, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 2'b11, 8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Illegal op is accepted but dropped; then clear together with a new overflow
        cycle(1'b1, 2'b10, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        check("tp4_illegal_dropped", {31'b0, bus.out_valid}, 32'd0);
        check("tp4_sticky_illegal", {31'b0, sticky_illegal}, 32'd1);
        cycle(1'b1, 2'b00, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check("tp4_clr_set_wins", {30'b0, sticky_ovf, sticky_illegal}, 32'd2);

        // Back-to-back push/pop across several pointer wraps
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, 2'b01, 8'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset while two entries are queued
        cycle(1'b1, 2'b00, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 2'b01, 8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        #3 RST = 1'b0;
        #1;
        check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("arst_out_result", {24'b0, bus.out_result}, 32'd0);
        check("arst_sticky", {29'b0, sticky_ovf, sticky_carry, sticky_illegal}, 32'd0);
        model_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        idle(1'b1);
        check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        cycle(1'b1, 2'b11, 8'hC3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
